// File: rtl/dlfloat_div_iter.sv
// Iterative DLFloat divider: restoring division, one quotient bit per clock,
// round-to-nearest-even, valid/ready on both sides.
module dlfloat_div_iter #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 9,
    localparam int W    = 1 + EXP_W + MAN_W,
    localparam int BIAS = (1 << (EXP_W - 1)) - 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] q,
    output logic [4:0]   flags
);

    localparam int QW = MAN_W + 3;
    localparam int CW = $clog2(QW + 1);
    localparam int EW = EXP_W + 2;
    localparam int RW = MAN_W + 2;
    localparam int MW = MAN_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        SPECIAL,
        DIV,
        RND,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] cnt;
    logic [W-1:0]  a_r, b_r;
    logic [RW-1:0] rem;
    logic [QW-1:0] quo;

    function automatic logic is_zero(input logic [W-1:0] x);
        return x[W-2:0] == '0;
    endfunction

    function automatic logic is_inf(input logic [W-1:0] x);
        return &x[W-2:0];
    endfunction

    logic in_special;
    logic last;
    logic sign;

    assign in_special = is_zero(a) | is_zero(b) | is_inf(a) | is_inf(b);
    assign last       = cnt == CW'(QW - 1);
    assign sign       = a_r[W-1] ^ b_r[W-1];
    assign in_ready   = state == IDLE;
    assign out_valid  = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = in_special ? SPECIAL : DIV;
            SPECIAL: state_nxt = DONE;
            DIV:     if (last) state_nxt = RND;
            RND:     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One restoring step: subtract divisor when it fits, then shift.
    logic [MW-1:0] mb;
    logic          ge;
    logic [RW-1:0] rem_sub;

    assign mb      = {1'b1, b_r[MAN_W-1:0]};
    assign ge      = rem >= {1'b0, mb};
    assign rem_sub = ge ? rem - {1'b0, mb} : rem;

    logic [W-1:0] spec_q;
    logic [4:0]   spec_f;
    logic         za, zb, ia, ib;

    assign za = is_zero(a_r);
    assign zb = is_zero(b_r);
    assign ia = is_inf(a_r);
    assign ib = is_inf(b_r);

    always_comb begin
        spec_q = {sign, {(W-1){1'b0}}};
        spec_f = 5'b00000;
        if ((za & zb) | (ia & ib)) begin
            spec_q = {sign, {(W-1){1'b1}}};
            spec_f = 5'b10000;
        end else if (zb) begin
            spec_q = {sign, {(W-1){1'b1}}};
            spec_f = 5'b00001;
        end else if (ia) begin
            spec_q = {sign, {(W-1){1'b1}}};
        end
    end

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] man, man_f;
    logic [MW-1:0]    man_p;
    logic [EW-1:0]    e_raw, e_fin;
    logic             guard, sticky, rnd_up, ovf, unf;
    logic [W-1:0]     rnd_q;
    logic [4:0]       rnd_f;

    assign ea = a_r[W-2:MAN_W];
    assign eb = b_r[W-2:MAN_W];

    // Exponent kept EXP_W+2 wide; top bit is the sign of the result exponent.
    always_comb begin
        man    = quo[QW-2:2];
        guard  = quo[1];
        sticky = quo[0] | (rem != '0);
        e_raw  = EW'(ea) - EW'(eb) + EW'(BIAS);
        if (!quo[QW-1]) begin
            man    = quo[QW-3:1];
            guard  = quo[0];
            sticky = rem != '0;
            e_raw  = e_raw - EW'(1);
        end
        rnd_up = guard & (sticky | man[0]);
        man_p  = {1'b0, man} + MW'(rnd_up);
        e_fin  = e_raw;
        man_f  = man_p[MAN_W-1:0];
        if (man_p[MAN_W]) begin
            e_fin = e_raw + EW'(1);
            man_f = '0;
        end
        ovf   = !e_fin[EW-1] &
                (e_fin[EXP_W] | (&{e_fin[EXP_W-1:0], man_f}));
        unf   = e_fin[EW-1] | ({e_fin[EXP_W-1:0], man_f} == '0);
        rnd_q = {sign, e_fin[EXP_W-1:0], man_f};
        rnd_f = {1'b0, guard | sticky, 3'b000};
        if (ovf) begin
            rnd_q = {sign, {(W-2){1'b1}}, 1'b0};
            rnd_f = 5'b01100;
        end else if (unf) begin
            rnd_q = {sign, {(W-1){1'b0}}};
            rnd_f = 5'b01010;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            rem   <= '0;
            quo   <= '0;
            q     <= '0;
            flags <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r <= a;
                        b_r <= b;
                        rem <= {1'b0, 1'b1, a[MAN_W-1:0]};
                        quo <= '0;
                        cnt <= '0;
                    end
                end
                SPECIAL: begin
                    q     <= spec_q;
                    flags <= spec_f;
                end
                DIV: begin
                    quo <= {quo[QW-2:0], ge};
                    rem <= {rem_sub[RW-2:0], 1'b0};
                    cnt <= cnt + CW'(1);
                end
                RND: begin
                    q     <= rnd_q;
                    flags <= rnd_f;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dlfloat_div_iter.sv
// Directed bench for dlfloat_div_iter: default DLFloat16 instance plus an
// EXP_W=8/MAN_W=7 instance.
module tb_dlfloat_div_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] q;
    logic [4:0]  flags;

    logic        in_valid8 = 1'b0;
    logic        out_ready8 = 1'b0;
    logic [15:0] a8 = '0;
    logic [15:0] b8 = '0;
    logic        in_ready8;
    logic        out_valid8;
    logic [15:0] q8;
    logic [4:0]  flags8;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dlfloat_div_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .flags     (flags)
    );

    dlfloat_div_iter #(
        .EXP_W (8),
        .MAN_W (7)
    ) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .q         (q8),
        .flags     (flags8)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic run_op(input string tag, input logic [15:0] va,
                          input logic [15:0] vb, input logic [15:0] exq,
                          input logic [4:0] exf, input int exlat);
        int n;
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        a = va;
        b = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'h5555;
        b = 16'h2AAA;
        n = 1;
        while (!out_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exlat));
        chk({tag, "_q"}, 32'(q), 32'(exq));
        chk({tag, "_flags"}, 32'(flags), 32'(exf));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_idle"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1;
        chk("rst_state", 32'({in_ready, out_valid, q, flags}),
            32'({1'b1, 1'b0, 16'h0000, 5'b00000}));
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("div13", 16'h3E00, 16'h4100, 16'h3AAB, 5'b01000, 14);
        run_op("div62", 16'h4300, 16'h4000, 16'h4100, 5'b00000, 14);
        run_op("neg62", 16'hC300, 16'h4000, 16'hC100, 5'b00000, 14);
        run_op("z_z",   16'h0000, 16'h8000, 16'hFFFF, 5'b10000, 2);
        run_op("x_z",   16'h3E00, 16'h0000, 16'h7FFF, 5'b00001, 2);
        run_op("i_i",   16'h7FFF, 16'hFFFF, 16'hFFFF, 5'b10000, 2);
        run_op("x_i",   16'h3E00, 16'h7FFF, 16'h0000, 5'b00000, 2);
        run_op("ovf",   16'h7FFE, 16'h0200, 16'h7FFE, 5'b01100, 14);
        run_op("unf",   16'h0200, 16'h7E00, 16'h0000, 5'b01010, 14);

        // Hold the result under backpressure while new operands are offered.
        a = 16'h4300;
        b = 16'h4000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_lat", 32'(n), 32'd14);
        for (int i = 0; i < 20; i++) begin
            a = 16'h3E00;
            b = 16'h4100;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_hold", 32'({out_valid, in_ready, q, flags}),
                32'({1'b1, 1'b0, 16'h4100, 5'b00000}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_rel", 32'({out_valid, in_ready}), 32'b01);
        @(posedge clk);
        #1;
        chk("bp_idle", 32'({out_valid, in_ready}), 32'b01);

        // Abort a division with an asynchronous reset.
        a = 16'h3E00;
        b = 16'h4100;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid", 32'({in_ready, out_valid, q, flags}),
            32'({1'b1, 1'b0, 16'h0000, 5'b00000}));
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("post_rst", 16'h4300, 16'h4000, 16'h4100, 5'b00000, 14);

        // EXP_W=8, MAN_W=7: 1.0/3.0.
        chk("p8_rdy", 32'(in_ready8), 32'd1);
        a8 = 16'h3F80;
        b8 = 16'h4040;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        n = 1;
        while (!out_valid8 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("p8_lat", 32'(n), 32'd12);
        chk("p8_q", 32'(q8), 32'h3EAB);
        chk("p8_flags", 32'(flags8), 32'(5'b01000));
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b0;
        chk("p8_idle", 32'({out_valid8, in_ready8}), 32'b01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dlfloat_div_iter.md
Name: dlfloat_div_iter

Overview:
- Parametrised, multi-cycle DLFloat divider computing a/b. Restoring division, one quotient bit per clock.
- Round-to-nearest-even to the input format (no widened output), 5-bit IEEE-style exception flags.
- valid/ready handshakes on input and output, so it drops into the FPU pipeline with backpressure.
- Default configuration is DLFloat16: 1 sign, 6 exponent, 9 mantissa bits, bias 31.

Parameters:
- EXP_W, 6, exponent field width.
- MAN_W, 9, stored mantissa width; hidden bit is always 1.
- W, 1+EXP_W+MAN_W, word width (derived, not overridable).
- BIAS, 2^(EXP_W-1)-1, exponent bias (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- a  in  W  dividend
- b  in  W  divisor
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- q  out  W  quotient
- flags  out  5  {invalid, inexact, overflow, underflow, div_by_zero}

Behaviour:
- Encodings:
  - all-ones magnitude = inf/NaN (0x7FFF/0xFFFF at default).
  - magnitude 0 = zero (0x0000/0x8000).
  - Every other pattern is normal with hidden 1, including exponent field 0. No subnormals.
- Reset: state IDLE, in_ready=1, out_valid=0, q=0, flags=0, counter=0. Reset asserted mid-division aborts it; the result is discarded.
- Accept: in_valid & in_ready on a rising edge. Operands are latched and sign = sa^sb. in_ready=1 only in IDLE.
- States:
  - IDLE -> SPECIAL if either operand is zero or inf/NaN; otherwise -> DIV.
  - SPECIAL -> DONE next edge.
  - DIV: runs MAN_W+3 cycles (counter). Each cycle: if rem>=mb then qbit=1, rem-=mb; then rem<<=1. rem is initialised to ma; ma and mb = {1, mantissa}. Bits are collected MSB-first.
  - DIV -> RND after the last bit.
  - RND: normalise, round, pack. -> DONE.
  - DONE: out_valid=1, q and flags held stable. -> IDLE on out_valid & out_ready.
- Latency: out_valid rises MAN_W+5 edges after accept for normal operands (14 at default), and 2 edges after accept for specials. No back-to-back overlap: next accept is possible the edge after the result is taken.
- Normalisation:
  - quotient MSB=1: mantissa = next MAN_W bits, guard = following bit, exp = ea-eb+BIAS.
  - else: shift left 1, exp = ea-eb+BIAS-1.
  - Exponent arithmetic is signed, EXP_W+2 bits.
- Rounding: sticky = remaining quotient bits | (rem!=0). RNE on guard/sticky/lsb. Mantissa carry-out increments exp and clears the mantissa. inexact = guard|sticky.
- Overflow: final exp > 2^EXP_W-1, or result encodes the all-ones magnitude. Output q = sign,max finite (0x7FFE/0xFFFE). Flags overflow+inexact.
- Underflow: final exp < 0, or packed magnitude equals 0. Output q = signed zero. Flags underflow+inexact.
- Specials, in priority order; sign is always sa^sb:
  1. 0/0 -> ±all-ones, invalid.
  2. inf/inf -> ±all-ones, invalid.
  3. x/0 -> ±all-ones, div_by_zero.
  4. inf/x -> ±all-ones, no flags.
  5. x/inf -> ±0, no flags.
  6. 0/x -> ±0, no flags.
- Inputs changing while not in IDLE have no effect.
- out_ready held low keeps q/flags stable indefinitely.

Test Plan:
- 0x3E00 / 0x4100 (1.0/3.0) -> q=0x3AAB, flags=5'b01000, out_valid 14 edges after accept.
- 0x4300 / 0x4000 (6.0/2.0) -> q=0x4100, flags=0. Also 0xC300 / 0x4000 -> q=0xC100, flags=0.
- Specials:
  - 0x0000/0x8000 -> 0xFFFF, flags=10000.
  - 0x3E00/0x0000 -> 0x7FFF, flags=00001.
  - 0x7FFF/0xFFFF -> 0xFFFF, flags=10000.
  - 0x3E00/0x7FFF -> 0x0000, flags=0.
  - out_valid 2 edges after accept in every case.
- 0x7FFE / 0x0200 -> q=0x7FFE, flags=01100. 0x0200 / 0x7E00 -> q=0x0000, flags=01010.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> q/flags stable, in_ready=0, new in_valid ignored. out_ready=1 -> one handshake, then IDLE, in_ready=1.
- rst_n pulsed low at DIV cycle 5 -> all outputs reset immediately (async). The next operation 0x4300/0x4000 completes correctly with 0x4100.
- Parameter sweep EXP_W=8, MAN_W=7: 1.0/3.0 (0x3F80/0x4040) -> 0x3EAB, inexact; latency 12 edges.
